// File: rtl/mips_loader_mem.sv
// Memory-side responder for the multicycle mips core: byte RAM plus STATUS/IO
// registers at the top of the address map, with a boot loader that fills RAM
// and holds the core in reset until the load completes.
module mips_loader_mem #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  input  logic             memread,
  input  logic             memwrite,
  output logic [WIDTH-1:0] memdata,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             cpu_rst,
  output logic [WIDTH-1:0] io_out,
  output logic             io_strobe
);

  localparam int unsigned    RAM_SIZE     = (2 ** WIDTH) - 2;
  localparam logic [WIDTH-1:0] ADR_IO       = '1;
  localparam logic [WIDTH-1:0] ADR_STATUS   = ADR_IO - WIDTH'(1);
  localparam logic [WIDTH-1:0] ADR_RAM_LAST = ADR_IO - WIDTH'(2);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ld_count_q;
  logic [WIDTH-1:0] ram [RAM_SIZE];

  logic             load_act;
  logic             ld_fire;
  logic             run_act;
  logic             core_wr;
  logic             adr_is_ram;

  // Loader is open only out of reset and while loading; reset closes it at once.
  assign load_act   = rst && (state_q == LOAD);
  assign ld_fire    = load_act && ld_valid;
  assign run_act    = rst && (state_q == RUN);
  assign core_wr    = run_act && memwrite;
  assign adr_is_ram = (adr <= ADR_RAM_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-derived outputs; load ends on last byte or full RAM.
  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    cpu_rst  = 1'b0;
    case (state_q)
      LOAD: begin
        ld_ready = rst;
        if (ld_fire && (ld_last || (ptr_q == ADR_RAM_LAST))) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cpu_rst = 1'b1;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Load pointer and saturating loaded-byte count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q      <= '0;
      ld_count_q <= '0;
    end else if (ld_fire) begin
      ptr_q <= ptr_q + WIDTH'(1);
      if (ld_count_q != ADR_STATUS) begin
        ld_count_q <= ld_count_q + WIDTH'(1);
      end
    end
  end

  // RAM write port, shared by loader (LOAD) and core (RUN); never reset.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      ram[ptr_q] <= ld_data;
    end else if (core_wr && adr_is_ram) begin
      ram[adr] <= writedata;
    end
  end

  // IO port register and its one-cycle write strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      io_out    <= '0;
      io_strobe <= 1'b0;
    end else begin
      io_strobe <= core_wr && (adr == ADR_IO);
      if (core_wr && (adr == ADR_IO)) begin
        io_out <= writedata;
      end
    end
  end

  // Zero-latency read mux; returns pre-edge contents on a simultaneous write.
  always_comb begin
    memdata = '0;
    if (run_act && memread) begin
      if (adr == ADR_IO) begin
        memdata = io_out;
      end else if (adr == ADR_STATUS) begin
        memdata = ld_count_q;
      end else begin
        memdata = ram[adr];
      end
    end
  end

endmodule

// File: tb/tb_mips_loader_mem.sv
// Directed bench for mips_loader_mem: load, overflow, IO, RAM, reset, ignores.
module tb_mips_loader_mem;

  logic       clk;
  logic       rst;
  logic [7:0] adr;
  logic [7:0] writedata;
  logic       memread;
  logic       memwrite;
  logic [7:0] memdata;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       cpu_rst;
  logic [7:0] io_out;
  logic       io_strobe;

  int n_vec;
  int n_err;

  mips_loader_mem #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .adr       (adr),
    .writedata (writedata),
    .memread   (memread),
    .memwrite  (memwrite),
    .memdata   (memdata),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .cpu_rst   (cpu_rst),
    .io_out    (io_out),
    .io_strobe (io_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it on mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic core_read(input logic [7:0] a, output logic [7:0] d);
    adr     = a;
    memread = 1'b1;
    #1;
    d       = memdata;
    memread = 1'b0;
    #1;
  endtask

  task automatic core_write(input logic [7:0] a, input logic [7:0] d);
    adr       = a;
    writedata = d;
    memwrite  = 1'b1;
    tick();
    memwrite  = 1'b0;
  endtask

  logic [7:0] rd;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0; adr = '0; writedata = '0; memread = 1'b0; memwrite = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_cpu_rst", 32'(cpu_rst), 32'h0);
    check("rst_ld_ready", 32'(ld_ready), 32'h0);
    check("rst_io_out", 32'(io_out), 32'h0);
    check("rst_io_strobe", 32'(io_strobe), 32'h0);
    rst = 1'b1;
    #1;
    check("load_ready", 32'(ld_ready), 32'h1);

    // Basic load of four bytes
    load_byte(8'h11, 1'b0);
    load_byte(8'h22, 1'b0);
    load_byte(8'h33, 1'b0);
    check("load_cpu_rst_held", 32'(cpu_rst), 32'h0);
    load_byte(8'h44, 1'b1);
    check("load_cpu_rst_rel", 32'(cpu_rst), 32'h1);
    check("load_ready_off", 32'(ld_ready), 32'h0);
    core_read(8'h00, rd); check("ram0", 32'(rd), 32'h11);
    core_read(8'h01, rd); check("ram1", 32'(rd), 32'h22);
    core_read(8'h02, rd); check("ram2", 32'(rd), 32'h33);
    core_read(8'h03, rd); check("ram3", 32'(rd), 32'h44);
    core_read(8'hFE, rd); check("status4", 32'(rd), 32'h04);

    // IO write, strobe and readback
    core_write(8'hFF, 8'h5A);
    check("io_out", 32'(io_out), 32'h5A);
    check("io_strobe_hi", 32'(io_strobe), 32'h1);
    tick();
    check("io_strobe_lo", 32'(io_strobe), 32'h0);
    core_read(8'hFF, rd); check("io_read", 32'(rd), 32'h5A);
    core_write(8'hFE, 8'h99);
    core_read(8'hFE, rd); check("status_ro", 32'(rd), 32'h04);

    // Back-to-back IO writes
    adr = 8'hFF; writedata = 8'h01; memwrite = 1'b1;
    tick();
    check("b2b_io1", 32'(io_out), 32'h01);
    check("b2b_stb1", 32'(io_strobe), 32'h1);
    writedata = 8'h02;
    tick();
    memwrite = 1'b0;
    check("b2b_io2", 32'(io_out), 32'h02);
    check("b2b_stb2", 32'(io_strobe), 32'h1);
    tick();
    check("b2b_stb_end", 32'(io_strobe), 32'h0);

    // RAM write with simultaneous read
    core_write(8'h10, 8'h3C);
    core_write(8'h05, 8'h5F);
    adr = 8'h10; writedata = 8'hA5; memread = 1'b1; memwrite = 1'b1;
    #1;
    check("rw_old", 32'(memdata), 32'h3C);
    tick();
    memwrite = 1'b0;
    #1;
    check("rw_new", 32'(memdata), 32'hA5);
    memread = 1'b0;
    #1;
    check("rd_idle_zero", 32'(memdata), 32'h0);

    // Loader ignored in RUN
    ld_valid = 1'b1; ld_data = 8'hEE; ld_last = 1'b1;
    #1;
    check("run_ready", 32'(ld_ready), 32'h0);
    tick(); tick(); tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    core_read(8'h00, rd); check("run_ram0_kept", 32'(rd), 32'h11);
    core_read(8'hFE, rd); check("run_status_kept", 32'(rd), 32'h04);

    // Reset from RUN, then mid-load reset
    rst = 1'b0;
    ld_valid = 1'b1; ld_data = 8'hDD;
    #1;
    check("rstcyc_ready", 32'(ld_ready), 32'h0);
    tick();
    ld_valid = 1'b0;
    check("rst2_cpu_rst", 32'(cpu_rst), 32'h0);
    check("rst2_io_out", 32'(io_out), 32'h0);
    rst = 1'b1;
    load_byte(8'h77, 1'b0);
    load_byte(8'h88, 1'b0);
    core_write(8'h05, 8'h55);
    core_read(8'h00, rd); check("load_memdata_zero", 32'(rd), 32'h0);
    rst = 1'b0;
    #1;
    check("midrst_ready", 32'(ld_ready), 32'h0);
    tick();
    check("midrst_cpu_rst", 32'(cpu_rst), 32'h0);
    check("midrst_io_out", 32'(io_out), 32'h0);
    check("midrst_ready2", 32'(ld_ready), 32'h0);
    rst = 1'b1;
    load_byte(8'h9C, 1'b1);
    check("reload_cpu_rst", 32'(cpu_rst), 32'h1);
    core_read(8'hFE, rd); check("reload_status", 32'(rd), 32'h01);
    core_read(8'h00, rd); check("reload_ram0", 32'(rd), 32'h9C);
    core_read(8'h01, rd); check("reload_ram1", 32'(rd), 32'h88);
    core_read(8'h05, rd); check("load_wr_ignored", 32'(rd), 32'h5F);

    // Overflow load of 254 bytes without last
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 253; i++) begin
      load_byte(8'(i) ^ 8'h5A, 1'b0);
    end
    check("ovf_cpu_rst_held", 32'(cpu_rst), 32'h0);
    check("ovf_ready_253", 32'(ld_ready), 32'h1);
    load_byte(8'd253 ^ 8'h5A, 1'b0);
    check("ovf_cpu_rst", 32'(cpu_rst), 32'h1);
    ld_valid = 1'b1; ld_data = 8'h00;
    #1;
    check("ovf_refused", 32'(ld_ready), 32'h0);
    tick();
    ld_valid = 1'b0;
    core_read(8'hFE, rd); check("ovf_status", 32'(rd), 32'hFE);
    core_read(8'hFD, rd); check("ovf_ramfd", 32'(rd), 32'hA7);
    core_read(8'h00, rd); check("ovf_ram0", 32'(rd), 32'h5A);
    core_read(8'hFF, rd); check("ovf_io", 32'(rd), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_loader_mem.md
# mips_loader_mem

Memory-side responder for the multicycle `mips` core. It answers the core's `memread`/`memwrite`/`adr`/`writedata` requests from a byte-wide RAM, and decodes the top two addresses as an output port and a status register. After reset it holds the core in reset while a byte-stream loader fills RAM through a valid/ready port. It releases the core once the load completes. It sits beside `mips` at the top level and drives the core's `rst`.

## Interface
- `WIDTH`, default 8: data and address width. RAM size is 2^WIDTH − 2 bytes.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `adr`  in  WIDTH  core byte address.
- `writedata`  in  WIDTH  core write data.
- `memread`  in  1  core read request.
- `memwrite`  in  1  core write request.
- `memdata`  out  WIDTH  read data returned to the core.
- `ld_valid`  in  1  loader byte valid.
- `ld_data`  in  WIDTH  loader byte.
- `ld_last`  in  1  marks the final loader byte; qualified by the handshake.
- `ld_ready`  out  1  block accepts a loader byte this cycle.
- `cpu_rst`  out  1  reset to the core, active-low; 0 holds the core in reset.
- `io_out`  out  WIDTH  output port register.
- `io_strobe`  out  1  one-cycle pulse on each write to `io_out`.

## Operation
- Address map, with TOP = 2^WIDTH − 1:
  - 0 … TOP−2: RAM.
  - TOP−1: STATUS. Read-only; returns `ld_count`.
  - TOP: IO. Read/write; backed by `io_out`.
- State machine has two states, LOAD and RUN.
- Reset (`rst`=0) sets:
  - state to LOAD, load pointer to 0, `ld_count` to 0;
  - `io_out` to 0, `io_strobe` to 0;
  - `cpu_rst` to 0, `ld_ready` to 0.
- RAM contents are not reset.
- LOAD behaviour:
  - `ld_ready` = 1 whenever `rst` = 1.
  - On a handshake (`ld_valid` & `ld_ready`), write `ld_data` to RAM[pointer], increment the pointer and increment `ld_count`.
  - Go to RUN on a handshake with `ld_last` = 1.
  - Also go to RUN on a handshake at pointer TOP−2, whatever `ld_last` is. This is the overflow cap; no byte is ever written to STATUS or IO by the loader.
- In LOAD, core requests are ignored: `memdata` = 0 and `memwrite` has no effect.
- RUN behaviour:
  - `ld_ready` = 0 and `ld_valid` is ignored.
  - `cpu_rst` = 1 (combinational from the state register).
  - The block stays in RUN until `rst` = 0.
- Core write (RUN, `memwrite` = 1):
  - to RAM: RAM[`adr`] ← `writedata` at the edge;
  - to IO: `io_out` ← `writedata` at the edge, and `io_strobe` = 1 for the following cycle only;
  - to STATUS: ignored.
- Core read (RUN, `memread` = 1): `memdata` is combinational in `adr`:
  - RAM[`adr`], `ld_count` or `io_out` according to the address map;
  - 0 when `memread` = 0.
- `memread` and `memwrite` asserted together: the write is performed, and the read returns the pre-edge value.

## Timing
- Reads have zero-cycle latency: `memdata` is valid in the same cycle as `adr`/`memread`, as the multicycle core requires.
- Writes commit at the rising edge in which `memwrite` is high. Data becomes readable in the next cycle.
- If the loader handshake with `ld_last` happens at edge N:
  - state = RUN and `cpu_rst` = 1 from cycle N+1;
  - the core's first fetch is in cycle N+1 or later.
- `io_strobe` is high exactly one cycle per IO write. Back-to-back IO writes give consecutive high cycles.
- `ld_count` saturates at TOP−1, the maximum number of bytes that can be loaded.
- Reset mid-operation (either state): all reset values apply from the next cycle. A handshake in the reset cycle is not accepted, because `ld_ready` = 0.

## Test plan
- Basic load: load bytes 0x11, 0x22, 0x33, 0x44 with `ld_last` on the fourth.
  - RAM[0..3] hold those bytes.
  - `cpu_rst` rises the cycle after the fourth handshake.
  - A core read of address 0xFE returns 0x04.
- Overflow load: load 254 bytes without `ld_last`.
  - Block enters RUN after the byte at 0xFD.
  - Byte 255 is refused (`ld_ready` = 0).
  - STATUS reads 0xFE.
- IO write: in RUN, write 0x5A to 0xFF.
  - `io_out` = 0x5A and `io_strobe` = 1 for one cycle.
  - A read of 0xFF returns 0x5A.
  - Writing 0x99 to 0xFE leaves STATUS unchanged.
- RAM write/read: in RUN, write 0xA5 to 0x10 while simultaneously reading 0x10.
  - Same-cycle `memdata` shows the old byte.
  - The next-cycle read returns 0xA5.
  - With `memread` = 0, `memdata` = 0.
- Mid-load reset: reset after 2 handshakes.
  - `ld_count` = 0, `cpu_rst` = 0, `io_out` = 0, `ld_ready` = 0 during reset.
  - Reloading 1 byte with `ld_last` writes it to RAM[0] and enters RUN.
- Ignored inputs:
  - In RUN, `ld_valid` pulses are ignored; RAM and `ld_count` are unchanged.
  - In LOAD, a core `memwrite` to 0x05 does not modify RAM[0x05].
